// File: rtl/md5_chunk_scheduler.sv
// Chunk dispatcher for the MD5 brute-force core array: splits the candidate space, tracks busy cores, handles hit/abort/pause.
// Latency: dispatch decided in RUNNING, core_start registered one cycle later; hit -> target/core_abort/FOUND one cycle later.
// Backpressure: a chunk is only issued to a core whose busy bit is clear; MD5_SCHED_STATS_EN adds dispatch/cycle counters.
module md5_chunk_scheduler #(
  parameter int N_CORES    = 4,
  parameter int CHUNK_BITS = 8,
  parameter int CAND_W     = 32
) (
  input  logic                        CLK,
  input  logic                        CPU_RESET,
  input  logic                        enable_switch,
  input  logic [127:0]                target_selected,
  output logic [127:0]                core_target,
  output logic [N_CORES-1:0]          core_start,
  output logic [N_CORES*CAND_W-1:0]   core_base,
  output logic                        core_abort,
  input  logic [N_CORES-1:0]          core_done,
  input  logic [N_CORES-1:0]          core_found,
  input  logic [N_CORES*CAND_W-1:0]   core_found_value,
  output logic [CAND_W-1:0]           target,
  output logic                        status_paused,
  output logic                        status_running,
  output logic                        status_warming,
  output logic                        status_found,
  output logic                        status_done
`ifdef MD5_SCHED_STATS_EN
  ,
  output logic [31:0]                 chunks_dispatched,
  output logic [31:0]                 search_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUNNING,
    S_PAUSED,
    S_DRAIN,
    S_FOUND,
    S_DONE
  } state_t;

  // One chunk worth of candidates, one bit wider than the base so the final chunk shows up as a carry.
  localparam logic [CAND_W:0] STEP = {{(CAND_W-CHUNK_BITS){1'b0}}, 1'b1, {CHUNK_BITS{1'b0}}};

  state_t                      state, state_nxt;
  logic [N_CORES-1:0]          busy, busy_nxt;
  logic [N_CORES-1:0]          dispatched, disp_nxt;
  logic [CAND_W-1:0]           next_base, base_nxt;
  logic [CAND_W:0]             base_sum;
  logic [127:0]                ctgt_nxt;
  logic [N_CORES-1:0]          start_nxt;
  logic [N_CORES*CAND_W-1:0]   cbase_nxt;
  logic                        abort_nxt;
  logic [CAND_W-1:0]           target_nxt;
  logic [N_CORES-1:0]          free_oh, hit_mask, hit_oh, done_mask;
  logic [CAND_W-1:0]           hit_val;

  // State register
  always_ff @(posedge CLK) begin
    if (CPU_RESET) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state, dispatch, hit and abort decisions
  always_comb begin
    state_nxt  = state;
    busy_nxt   = busy;
    disp_nxt   = dispatched;
    base_nxt   = next_base;
    ctgt_nxt   = core_target;
    start_nxt  = '0;
    cbase_nxt  = core_base;
    abort_nxt  = 1'b0;
    target_nxt = target;
    base_sum   = {1'b0, next_base} + STEP;

    // Lowest free core and lowest reporting hit; reports from idle cores are stale and dropped.
    free_oh   = ~busy & (busy + N_CORES'(1));
    hit_mask  = core_found & busy;
    hit_oh    = hit_mask & (~hit_mask + N_CORES'(1));
    done_mask = core_done & busy;
    hit_val   = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (hit_oh[i]) hit_val = core_found_value[i*CAND_W +: CAND_W];
    end

    case (state)
      S_IDLE: begin
        if (enable_switch) begin
          ctgt_nxt   = target_selected;
          base_nxt   = '0;
          target_nxt = '0;
          busy_nxt   = '0;
          disp_nxt   = '0;
          state_nxt  = S_RUNNING;
        end
      end
      S_RUNNING, S_PAUSED, S_DRAIN: begin
        busy_nxt = busy & ~done_mask;
        if (|hit_oh) begin
          // A hit beats a same-cycle done and suppresses dispatch so start and abort never overlap.
          target_nxt = hit_val;
          abort_nxt  = 1'b1;
          busy_nxt   = '0;
          state_nxt  = S_FOUND;
        end else if (state == S_RUNNING) begin
          if (!enable_switch) begin
            state_nxt = S_PAUSED;
          end else if (|free_oh) begin
            start_nxt = free_oh;
            busy_nxt  = busy_nxt | free_oh;
            disp_nxt  = dispatched | free_oh;
            base_nxt  = base_sum[CAND_W-1:0];
            if (base_sum[CAND_W]) state_nxt = S_DRAIN;
          end
        end else if (state == S_PAUSED) begin
          if (enable_switch) begin
            state_nxt = S_RUNNING;
            if (target_selected != core_target) begin
              // New digest: throw away in-flight work and restart the space from zero.
              abort_nxt = 1'b1;
              busy_nxt  = '0;
              ctgt_nxt  = target_selected;
              base_nxt  = '0;
              disp_nxt  = '0;
            end
          end
        end else begin
          if (busy == '0) state_nxt = S_DONE;
        end
      end
      S_FOUND, S_DONE: begin
        if (!enable_switch) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    for (int i = 0; i < N_CORES; i++) begin
      if (start_nxt[i]) cbase_nxt[i*CAND_W +: CAND_W] = next_base;
    end
  end

  // Registered datapath and outputs; status reflects the state being entered
  always_ff @(posedge CLK) begin
    if (CPU_RESET) begin
      busy           <= '0;
      dispatched     <= '0;
      next_base      <= '0;
      core_target    <= '0;
      core_start     <= '0;
      core_base      <= '0;
      core_abort     <= 1'b0;
      target         <= '0;
      status_paused  <= 1'b0;
      status_running <= 1'b0;
      status_warming <= 1'b0;
      status_found   <= 1'b0;
      status_done    <= 1'b0;
    end else begin
      busy           <= busy_nxt;
      dispatched     <= disp_nxt;
      next_base      <= base_nxt;
      core_target    <= ctgt_nxt;
      core_start     <= start_nxt;
      core_base      <= cbase_nxt;
      core_abort     <= abort_nxt;
      target         <= target_nxt;
      status_paused  <= (state_nxt == S_PAUSED);
      status_running <= (state_nxt == S_RUNNING) || (state_nxt == S_DRAIN);
      status_warming <= (state_nxt == S_RUNNING) && !(&disp_nxt);
      status_found   <= (state_nxt == S_FOUND);
      status_done    <= (state_nxt == S_DONE);
    end
  end

`ifdef MD5_SCHED_STATS_EN
  // Saturating search statistics, restarted when a new search leaves IDLE
  always_ff @(posedge CLK) begin
    if (CPU_RESET || (state == S_IDLE && enable_switch)) begin
      chunks_dispatched <= '0;
      search_cycles     <= '0;
    end else begin
      if (|core_start && chunks_dispatched != '1)
        chunks_dispatched <= chunks_dispatched + 32'd1;
      if ((state == S_RUNNING || state == S_DRAIN) && search_cycles != '1)
        search_cycles <= search_cycles + 32'd1;
    end
  end
`endif

endmodule
